// File: rtl/qar_i2c_pkg.sv
// Shared constants for the qar_i2c transaction sequencer: register words,
// command/status bits, response codes, FSM encoding and step sequencing.
package qar_i2c_pkg;

  localparam int SEQ_NUM_REQ = 2;
  localparam int I2C_ADDR_W  = 6;
  localparam int I2C_DATA_W  = 32;

  localparam logic [I2C_ADDR_W-1:0] I2C_REG_STATUS = 6'd2;
  localparam logic [I2C_ADDR_W-1:0] I2C_REG_TXDATA = 6'd5;
  localparam logic [I2C_ADDR_W-1:0] I2C_REG_RXDATA = 6'd6;
  localparam logic [I2C_ADDR_W-1:0] I2C_REG_CMD    = 6'd7;

  localparam logic [I2C_DATA_W-1:0] CMD_START = 32'h1;
  localparam logic [I2C_DATA_W-1:0] CMD_STOP  = 32'h2;
  localparam logic [I2C_DATA_W-1:0] CMD_WRITE = 32'h4;
  localparam logic [I2C_DATA_W-1:0] CMD_READ  = 32'h8;

  localparam int STATUS_BUSY_BIT    = 0;
  localparam int STATUS_ACK_ERR_BIT = 3;
  localparam logic [I2C_DATA_W-1:0] STATUS_ACK_CLR = 32'h8;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_NACK    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  typedef enum logic [3:0] {
    ST_IDLE, ST_TXPUSH, ST_CMD, ST_GUARD, ST_POLL,
    ST_CHECK, ST_CLRACK, ST_FETCH, ST_ABORT, ST_DONE
  } seq_state_e;

  // Step indices; a write runs 0-1-2-3-8, a read runs 0-1-2-4-5-6-7-8.
  localparam logic [3:0] STEP_START  = 4'd0;
  localparam logic [3:0] STEP_DEV_W  = 4'd1;
  localparam logic [3:0] STEP_REG    = 4'd2;
  localparam logic [3:0] STEP_WDATA  = 4'd3;
  localparam logic [3:0] STEP_RSTART = 4'd4;
  localparam logic [3:0] STEP_DEV_R  = 4'd5;
  localparam logic [3:0] STEP_READ   = 4'd6;
  localparam logic [3:0] STEP_FETCH  = 4'd7;
  localparam logic [3:0] STEP_STOP   = 4'd8;

  function automatic logic [3:0] step_after(input logic [3:0] step, input logic rnw);
    case (step)
      STEP_START:  return STEP_DEV_W;
      STEP_DEV_W:  return STEP_REG;
      STEP_REG:    return rnw ? STEP_RSTART : STEP_WDATA;
      STEP_RSTART: return STEP_DEV_R;
      STEP_DEV_R:  return STEP_READ;
      STEP_READ:   return STEP_FETCH;
      default:     return STEP_STOP;
    endcase
  endfunction

  function automatic logic is_tx_step(input logic [3:0] step);
    return (step == STEP_DEV_W) || (step == STEP_REG) ||
           (step == STEP_WDATA) || (step == STEP_DEV_R);
  endfunction

endpackage

// File: rtl/qar_i2c_seq_if.sv
// Word-addressed register port between the sequencer (master) and qar_i2c (slave).
interface qar_i2c_seq_if;
  import qar_i2c_pkg::*;

  logic                  m_write;
  logic                  m_read;
  logic [I2C_ADDR_W-1:0] m_addr;
  logic [I2C_DATA_W-1:0] m_wdata;
  logic [I2C_DATA_W-1:0] m_rdata;

  modport master (output m_write, m_read, m_addr, m_wdata, input m_rdata);
  modport slave  (input m_write, m_read, m_addr, m_wdata, output m_rdata);
endinterface

// File: rtl/qar_i2c_seq_arb.sv
// Two-way round-robin arbiter: picks rr_ptr when it is requesting, else the other;
// accept is a same-cycle strobe so the caller captures fields on that edge.
module qar_i2c_seq_arb
  import qar_i2c_pkg::*;
(
  input  logic [SEQ_NUM_REQ-1:0] req_valid,
  input  logic                   rr_ptr,
  input  logic                   idle,
  output logic                   grant,
  output logic [SEQ_NUM_REQ-1:0] accept
);

  assign grant = req_valid[rr_ptr] ? rr_ptr : ~rr_ptr;

  for (genvar gi = 0; gi < SEQ_NUM_REQ; gi++) begin : g_accept
    assign accept[gi] = idle && req_valid[gi] && (grant == 1'(gi));
  end

endmodule

// File: rtl/qar_i2c_seq.sv
// Transaction sequencer: turns byte-register read/write requests from two
// requesters into full START/addr/reg/data/STOP sequences on qar_i2c's register port.
module qar_i2c_seq
  import qar_i2c_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int GUARD_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_rnw,
  input  logic [7*NUM_REQ-1:0] req_dev,
  input  logic [8*NUM_REQ-1:0] req_reg,
  input  logic [8*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   req_accept,
  output logic [NUM_REQ-1:0]   rsp_done,
  output logic [1:0]           rsp_err,
  output logic [7:0]           rsp_rdata,
  qar_i2c_seq_if.master        m,
  output logic                 busy
);

  localparam int GW   = $clog2(GUARD_CYCLES + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);
  localparam logic [TO_W:0] TO_LIMIT   = (TO_W + 1)'(TIMEOUT_CYCLES);

  seq_state_e            state_reg;
  logic [3:0]            step_reg;
  logic                  gnt_reg;
  logic                  rr_ptr_reg;
  logic                  rnw_reg;
  logic [6:0]            dev_reg;
  logic [7:0]            reg_addr_reg;
  logic [7:0]            wdata_reg;
  logic [7:0]            rdata_reg;
  logic [1:0]            err_reg;
  logic                  nack_reg;
  logic                  abort_reg;
  logic                  ack_seen_reg;
  logic [GW-1:0]         guard_cnt_reg;
  logic [TO_W-1:0]       to_cnt_reg;
  logic [TO_W:0]         to_inc;

  logic                  m_write_reg;
  logic                  m_read_reg;
  logic [I2C_ADDR_W-1:0] m_addr_reg;
  logic [I2C_DATA_W-1:0] m_wdata_reg;
  logic [NUM_REQ-1:0]    rsp_done_reg;
  logic [1:0]            rsp_err_reg;
  logic [7:0]            rsp_rdata_reg;

  logic [6:0] dev_arr   [NUM_REQ];
  logic [7:0] reg_arr   [NUM_REQ];
  logic [7:0] wdata_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign dev_arr[gi]   = req_dev[7*gi +: 7];
    assign reg_arr[gi]   = req_reg[8*gi +: 8];
    assign wdata_arr[gi] = req_wdata[8*gi +: 8];
  end

  logic                   arb_idle;
  logic                   arb_grant;
  logic [SEQ_NUM_REQ-1:0] arb_accept;

  assign arb_idle = (state_reg == ST_IDLE) && !rst;

  qar_i2c_seq_arb u_arb (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_reg),
    .idle      (arb_idle),
    .grant     (arb_grant),
    .accept    (arb_accept)
  );

  // Upper read-data bits carry nothing this block needs.
  logic unused_rdata_hi;
  assign unused_rdata_hi = ^m.m_rdata[I2C_DATA_W-1:8];

  assign to_inc = {1'b0, to_cnt_reg} + (TO_W + 1)'(1);

  // Bus operation that opens the next step (first step when leaving IDLE).
  logic [3:0]            nxt_step;
  seq_state_e            launch_state;
  logic                  launch_wr;
  logic                  launch_rd;
  logic [I2C_ADDR_W-1:0] launch_addr;
  logic [I2C_DATA_W-1:0] launch_wdata;

  always_comb begin
    nxt_step     = (state_reg == ST_IDLE) ? STEP_START : step_after(step_reg, rnw_reg);
    launch_state = ST_CMD;
    launch_wr    = 1'b1;
    launch_rd    = 1'b0;
    launch_addr  = I2C_REG_CMD;
    launch_wdata = '0;
    case (nxt_step)
      STEP_START, STEP_RSTART: launch_wdata = CMD_START;
      STEP_READ:               launch_wdata = CMD_READ;
      STEP_STOP:               launch_wdata = CMD_STOP;
      STEP_FETCH: begin
        launch_state = ST_FETCH;
        launch_wr    = 1'b0;
        launch_rd    = 1'b1;
        launch_addr  = I2C_REG_RXDATA;
      end
      default: begin
        launch_state = ST_TXPUSH;
        launch_addr  = I2C_REG_TXDATA;
        case (nxt_step)
          STEP_DEV_W: launch_wdata = {24'h0, dev_reg, 1'b0};
          STEP_REG:   launch_wdata = {24'h0, reg_addr_reg};
          STEP_WDATA: launch_wdata = {24'h0, wdata_reg};
          default:    launch_wdata = {24'h0, dev_reg, 1'b1};
        endcase
      end
    endcase
  end

  logic [NUM_REQ-1:0] done_vec;
  logic [7:0]         done_rdata;

  always_comb begin
    done_vec          = '0;
    done_vec[gnt_reg] = 1'b1;
    done_rdata        = (rnw_reg && err_reg == ERR_OK) ? rdata_reg : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      step_reg      <= '0;
      gnt_reg       <= 1'b0;
      rr_ptr_reg    <= 1'b0;
      rnw_reg       <= 1'b0;
      dev_reg       <= '0;
      reg_addr_reg  <= '0;
      wdata_reg     <= '0;
      rdata_reg     <= '0;
      err_reg       <= ERR_OK;
      nack_reg      <= 1'b0;
      abort_reg     <= 1'b0;
      ack_seen_reg  <= 1'b0;
      guard_cnt_reg <= '0;
      to_cnt_reg    <= '0;
      m_write_reg   <= 1'b0;
      m_read_reg    <= 1'b0;
      m_addr_reg    <= '0;
      m_wdata_reg   <= '0;
      rsp_done_reg  <= '0;
      rsp_err_reg   <= ERR_OK;
      rsp_rdata_reg <= '0;
    end else begin
      m_write_reg   <= 1'b0;
      m_read_reg    <= 1'b0;
      m_addr_reg    <= '0;
      m_wdata_reg   <= '0;
      rsp_done_reg  <= '0;
      rsp_err_reg   <= ERR_OK;
      rsp_rdata_reg <= '0;

      case (state_reg)
        ST_IDLE: begin
          if (|arb_accept) begin
            gnt_reg      <= arb_grant;
            rr_ptr_reg   <= ~arb_grant;
            rnw_reg      <= req_rnw[arb_grant];
            dev_reg      <= dev_arr[arb_grant];
            reg_addr_reg <= reg_arr[arb_grant];
            wdata_reg    <= wdata_arr[arb_grant];
            rdata_reg    <= '0;
            err_reg      <= ERR_OK;
            nack_reg     <= 1'b0;
            abort_reg    <= 1'b0;
            step_reg     <= nxt_step;
            state_reg    <= launch_state;
            m_write_reg  <= launch_wr;
            m_read_reg   <= launch_rd;
            m_addr_reg   <= launch_addr;
            m_wdata_reg  <= launch_wdata;
          end
        end

        ST_TXPUSH: begin
          state_reg   <= ST_CMD;
          m_write_reg <= 1'b1;
          m_addr_reg  <= I2C_REG_CMD;
          m_wdata_reg <= CMD_WRITE;
        end

        ST_CMD: begin
          state_reg     <= ST_GUARD;
          guard_cnt_reg <= '0;
          to_cnt_reg    <= '0;
        end

        ST_GUARD: begin
          if (guard_cnt_reg == GUARD_LAST) begin
            if (abort_reg) begin
              state_reg     <= ST_DONE;
              rsp_done_reg  <= done_vec;
              rsp_err_reg   <= err_reg;
              rsp_rdata_reg <= done_rdata;
            end else begin
              state_reg  <= ST_POLL;
              m_read_reg <= 1'b1;
              m_addr_reg <= I2C_REG_STATUS;
            end
          end else begin
            guard_cnt_reg <= guard_cnt_reg + GW'(1);
          end
        end

        ST_POLL: begin
          ack_seen_reg <= m.m_rdata[STATUS_ACK_ERR_BIT];
          if (!m.m_rdata[STATUS_BUSY_BIT]) begin
            if (is_tx_step(step_reg)) begin
              state_reg <= ST_CHECK;
            end else if (step_reg == STEP_STOP) begin
              state_reg     <= ST_DONE;
              rsp_done_reg  <= done_vec;
              rsp_err_reg   <= err_reg;
              rsp_rdata_reg <= done_rdata;
            end else begin
              step_reg    <= nxt_step;
              state_reg   <= launch_state;
              m_write_reg <= launch_wr;
              m_read_reg  <= launch_rd;
              m_addr_reg  <= launch_addr;
              m_wdata_reg <= launch_wdata;
            end
          end else if (to_inc == TO_LIMIT) begin
            // A stuck STOP after a NACK still reports the NACK, not a timeout.
            if (nack_reg) begin
              state_reg     <= ST_DONE;
              rsp_done_reg  <= done_vec;
              rsp_err_reg   <= err_reg;
              rsp_rdata_reg <= done_rdata;
            end else begin
              state_reg   <= ST_ABORT;
              err_reg     <= ERR_TIMEOUT;
              abort_reg   <= 1'b1;
              m_write_reg <= 1'b1;
              m_addr_reg  <= I2C_REG_CMD;
              m_wdata_reg <= CMD_STOP;
            end
          end else begin
            to_cnt_reg <= to_inc[TO_W-1:0];
            m_read_reg <= 1'b1;
            m_addr_reg <= I2C_REG_STATUS;
          end
        end

        ST_CHECK: begin
          if (ack_seen_reg) begin
            state_reg   <= ST_CLRACK;
            err_reg     <= ERR_NACK;
            nack_reg    <= 1'b1;
            m_write_reg <= 1'b1;
            m_addr_reg  <= I2C_REG_STATUS;
            m_wdata_reg <= STATUS_ACK_CLR;
          end else begin
            step_reg    <= nxt_step;
            state_reg   <= launch_state;
            m_write_reg <= launch_wr;
            m_read_reg  <= launch_rd;
            m_addr_reg  <= launch_addr;
            m_wdata_reg <= launch_wdata;
          end
        end

        ST_CLRACK: begin
          state_reg   <= ST_CMD;
          step_reg    <= STEP_STOP;
          m_write_reg <= 1'b1;
          m_addr_reg  <= I2C_REG_CMD;
          m_wdata_reg <= CMD_STOP;
        end

        ST_FETCH: begin
          rdata_reg   <= m.m_rdata[7:0];
          step_reg    <= nxt_step;
          state_reg   <= launch_state;
          m_write_reg <= launch_wr;
          m_read_reg  <= launch_rd;
          m_addr_reg  <= launch_addr;
          m_wdata_reg <= launch_wdata;
        end

        ST_ABORT: begin
          state_reg     <= ST_GUARD;
          guard_cnt_reg <= '0;
        end

        ST_DONE: state_reg <= ST_IDLE;

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign req_accept = arb_accept;
  assign rsp_done   = rsp_done_reg;
  assign rsp_err    = rsp_err_reg;
  assign rsp_rdata  = rsp_rdata_reg;
  assign busy       = (state_reg != ST_IDLE);
  assign m.m_write  = m_write_reg;
  assign m.m_read   = m_read_reg;
  assign m.m_addr   = m_addr_reg;
  assign m.m_wdata  = m_wdata_reg;

endmodule
